// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback stage.
//   wb_state_t : writeback FSM state
//   SRC_*      : result source indices seen by wb_src_mux
package wb_pkg;

  typedef enum logic {
    WB_IDLE,
    WB_WAIT_MEM
  } wb_state_t;

  localparam int unsigned SRC_ALU = 0;
  localparam int unsigned SRC_MEM = 1;
  localparam int unsigned SRC_IMM = 2;

endpackage

// File: rtl/writeback_unit_src_mux.sv
// Combinational N_SRC x DATA_W result select.
//   sel_i  : source index
//   data_i : packed source values, entry i at data_i[i]
//   data_o : selected value, zero when sel_i is out of range
module wb_src_mux #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_SRC  = 3,
  parameter int unsigned SEL_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [SEL_W-1:0]             sel_i,
  input  logic [N_SRC-1:0][DATA_W-1:0] data_i,
  output logic [DATA_W-1:0]            data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (sel_i == SEL_W'(i)) begin
        data_o = data_i[i];
      end
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback stage: selects a result source and registers the
// write. Memory-sourced writes wait for the load response (or time out).
//   clk_i, rst_ni          : clock, async active-low reset
//   in_valid_i/in_ready_o  : instruction handshake
//   in_reg_write_i         : instruction writes a register
//   in_src_sel_i, in_rd_i  : result source and destination register
//   src_data_i             : non-memory source values
//   mem_rsp_valid_i/mem_rdata_i : load response
//   rf_we_o/rf_waddr_o/rf_wdata_o : registered register-file write
//   mem_timeout_o          : one-cycle pulse, pending load abandoned
//   spurious_rsp_o         : sticky, response seen with no load pending
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RA_W     = 4,
  parameter int unsigned N_SRC    = 3,
  parameter int unsigned MEM_SRC  = SRC_MEM,
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned SEL_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic                         in_reg_write_i,
  input  logic [SEL_W-1:0]             in_src_sel_i,
  input  logic [RA_W-1:0]              in_rd_i,
  input  logic [N_SRC-1:0][DATA_W-1:0] src_data_i,
  input  logic                         mem_rsp_valid_i,
  input  logic [DATA_W-1:0]            mem_rdata_i,
  output logic                         rf_we_o,
  output logic [RA_W-1:0]              rf_waddr_o,
  output logic [DATA_W-1:0]            rf_wdata_o,
  output logic                         mem_timeout_o,
  output logic                         spurious_rsp_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  wb_state_t         state_q;
  logic [CntW-1:0]   cnt_q;
  logic [RA_W-1:0]   rd_q;
  logic              rf_we_q;
  logic [RA_W-1:0]   rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              timeout_q;
  logic              spurious_q;

  logic [DATA_W-1:0] mux_data;
  logic              accept, sel_ok, wr_ok, is_mem, load_take;
  logic              wr_req, wr_en;
  logic [RA_W-1:0]   wr_rd;
  logic [DATA_W-1:0] wr_val;
  logic [CntW-1:0]   cnt_inc;

  wb_src_mux #(
    .DATA_W (DATA_W),
    .N_SRC  (N_SRC),
    .SEL_W  (SEL_W)
  ) u_src_mux (
    .sel_i  (in_src_sel_i),
    .data_i (src_data_i),
    .data_o (mux_data)
  );

  assign in_ready_o = (state_q == WB_IDLE);
  assign accept     = in_valid_i && in_ready_o;
  // An out-of-range source behaves like an instruction with no register write.
  assign sel_ok     = 32'(in_src_sel_i) < N_SRC;
  assign wr_ok      = in_reg_write_i && sel_ok;
  assign is_mem     = (in_src_sel_i == SEL_W'(MEM_SRC));
  // Only an accepted, register-writing load consumes a response seen in idle.
  assign load_take  = accept && wr_ok && is_mem;
  assign cnt_inc    = cnt_q + CntW'(1);

  always_comb begin
    wr_req = 1'b0;
    wr_rd  = in_rd_i;
    wr_val = mux_data;
    unique case (state_q)
      WB_IDLE: begin
        if (accept && wr_ok) begin
          if (!is_mem) begin
            wr_req = 1'b1;
          end else if (mem_rsp_valid_i) begin
            wr_req = 1'b1;
            wr_val = mem_rdata_i;
          end
        end
      end
      WB_WAIT_MEM: begin
        if (mem_rsp_valid_i) begin
          wr_req = 1'b1;
          wr_rd  = rd_q;
          wr_val = mem_rdata_i;
        end
      end
      default: ;
    endcase
  end

  assign wr_en = wr_req && !((ZERO_REG != 0) && (wr_rd == '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= WB_IDLE;
      cnt_q      <= '0;
      rd_q       <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      timeout_q  <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      rf_we_q   <= wr_en;
      timeout_q <= 1'b0;
      // Address/data hold between writes so they remain a stable forward source.
      if (wr_en) begin
        rf_waddr_q <= wr_rd;
        rf_wdata_q <= wr_val;
      end
      if ((state_q == WB_IDLE) && mem_rsp_valid_i && !load_take) begin
        spurious_q <= 1'b1;
      end
      unique case (state_q)
        WB_IDLE: begin
          if (load_take && !mem_rsp_valid_i) begin
            rd_q    <= in_rd_i;
            cnt_q   <= '0;
            state_q <= WB_WAIT_MEM;
          end
        end
        WB_WAIT_MEM: begin
          cnt_q <= cnt_inc;
          // A response on the final wait cycle takes priority over the timeout.
          if (mem_rsp_valid_i) begin
            state_q <= WB_IDLE;
          end else if (cnt_inc == CntW'(TIMEOUT)) begin
            timeout_q <= 1'b1;
            state_q   <= WB_IDLE;
          end
        end
        default: state_q <= WB_IDLE;
      endcase
    end
  end

  assign rf_we_o        = rf_we_q;
  assign rf_waddr_o     = rf_waddr_q;
  assign rf_wdata_o     = rf_wdata_q;
  assign mem_timeout_o  = timeout_q;
  assign spurious_rsp_o = spurious_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with default parameters.
module tb_writeback_unit;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            in_valid;
  logic            in_ready;
  logic            in_reg_write;
  logic [1:0]      in_src_sel;
  logic [3:0]      in_rd;
  logic [2:0][7:0] src_data;
  logic            mem_rsp_valid;
  logic [7:0]      mem_rdata;
  logic            rf_we;
  logic [3:0]      rf_waddr;
  logic [7:0]      rf_wdata;
  logic            mem_timeout;
  logic            spurious_rsp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  writeback_unit dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_reg_write_i  (in_reg_write),
    .in_src_sel_i    (in_src_sel),
    .in_rd_i         (in_rd),
    .src_data_i      (src_data),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rdata_i     (mem_rdata),
    .rf_we_o         (rf_we),
    .rf_waddr_o      (rf_waddr),
    .rf_wdata_o      (rf_wdata),
    .mem_timeout_o   (mem_timeout),
    .spurious_rsp_o  (spurious_rsp)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [1:0] sel, input logic [3:0] rd);
    in_valid     = 1'b1;
    in_reg_write = wr;
    in_src_sel   = sel;
    in_rd        = rd;
  endtask

  task automatic idle_in();
    in_valid      = 1'b0;
    in_reg_write  = 1'b0;
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    rst_ni        = 1'b0;
    in_valid      = 1'b0;
    in_reg_write  = 1'b0;
    in_src_sel    = 2'd0;
    in_rd         = 4'd0;
    src_data[0]   = 8'h5A;
    src_data[1]   = 8'hEE;
    src_data[2]   = 8'h77;
    mem_rsp_valid = 1'b0;
    mem_rdata     = 8'h00;
    #2;
    check_eq("rst_ready", in_ready, 1);
    check_eq("rst_we", rf_we, 0);
    check_eq("rst_waddr", rf_waddr, 0);
    check_eq("rst_wdata", rf_wdata, 0);
    check_eq("rst_timeout", mem_timeout, 0);
    check_eq("rst_spurious", spurious_rsp, 0);
    tick();
    rst_ni = 1'b1;

    // ALU write, then back-to-back immediate write.
    issue(1'b1, 2'd0, 4'd3);
    tick();
    check_eq("alu_we", rf_we, 1);
    check_eq("alu_waddr", rf_waddr, 3);
    check_eq("alu_wdata", rf_wdata, 8'h5A);
    check_eq("alu_ready", in_ready, 1);
    issue(1'b1, 2'd2, 4'd7);
    tick();
    check_eq("imm_we", rf_we, 1);
    check_eq("imm_waddr", rf_waddr, 7);
    check_eq("imm_wdata", rf_wdata, 8'h77);
    idle_in();
    tick();
    check_eq("hold_we", rf_we, 0);
    check_eq("hold_waddr", rf_waddr, 7);
    check_eq("hold_wdata", rf_wdata, 8'h77);

    // Load with response in the accept cycle.
    issue(1'b1, 2'd1, 4'd4);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 8'hC3;
    tick();
    check_eq("ld0_we", rf_we, 1);
    check_eq("ld0_waddr", rf_waddr, 4);
    check_eq("ld0_wdata", rf_wdata, 8'hC3);
    check_eq("ld0_ready", in_ready, 1);
    check_eq("ld0_spurious", spurious_rsp, 0);
    idle_in();

    // Load with response 3 cycles after accept.
    issue(1'b1, 2'd1, 4'd5);
    tick();
    idle_in();
    for (int i = 1; i <= 3; i++) begin
      check_eq("ld3_ready_low", in_ready, 0);
      check_eq("ld3_no_we", rf_we, 0);
      if (i < 3) tick();
    end
    mem_rsp_valid = 1'b1;
    mem_rdata     = 8'h11;
    tick();
    mem_rsp_valid = 1'b0;
    check_eq("ld3_we", rf_we, 1);
    check_eq("ld3_waddr", rf_waddr, 5);
    check_eq("ld3_wdata", rf_wdata, 8'h11);
    check_eq("ld3_ready", in_ready, 1);
    check_eq("ld3_spurious", spurious_rsp, 0);

    // Load that times out: pulse 16 cycles after accept.
    issue(1'b1, 2'd1, 4'd6);
    tick();
    idle_in();
    for (int i = 1; i <= 15; i++) begin
      check_eq("to_wait_ready", in_ready, 0);
      check_eq("to_wait_pulse", mem_timeout, 0);
      tick();
    end
    check_eq("to_pulse", mem_timeout, 1);
    check_eq("to_no_we", rf_we, 0);
    check_eq("to_ready", in_ready, 1);
    check_eq("to_waddr_hold", rf_waddr, 5);
    tick();
    check_eq("to_pulse_once", mem_timeout, 0);

    // Response on the last wait cycle beats the timeout.
    issue(1'b1, 2'd1, 4'd9);
    tick();
    idle_in();
    for (int i = 1; i < 15; i++) tick();
    check_eq("edge_ready_low", in_ready, 0);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 8'hA5;
    tick();
    mem_rsp_valid = 1'b0;
    check_eq("edge_we", rf_we, 1);
    check_eq("edge_waddr", rf_waddr, 9);
    check_eq("edge_wdata", rf_wdata, 8'hA5);
    check_eq("edge_no_timeout", mem_timeout, 0);
    check_eq("edge_ready", in_ready, 1);

    // Out-of-range source: no write.
    issue(1'b1, 2'd3, 4'd2);
    tick();
    check_eq("oor_we", rf_we, 0);
    check_eq("oor_waddr", rf_waddr, 9);

    // Writes to r0 are suppressed, for both ALU and load.
    issue(1'b1, 2'd0, 4'd0);
    tick();
    check_eq("zero_alu_we", rf_we, 0);
    issue(1'b1, 2'd1, 4'd0);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 8'h99;
    tick();
    check_eq("zero_ld_we", rf_we, 0);
    check_eq("zero_ld_spurious", spurious_rsp, 0);
    check_eq("zero_wdata_hold", rf_wdata, 8'hA5);

    // Response with a non-writing memory-sourced instruction is spurious.
    issue(1'b0, 2'd1, 4'd8);
    mem_rsp_valid = 1'b1;
    tick();
    idle_in();
    check_eq("spur_we", rf_we, 0);
    check_eq("spur_set", spurious_rsp, 1);
    tick();
    tick();
    check_eq("spur_sticky", spurious_rsp, 1);

    // Reset during a pending load, then a late response.
    issue(1'b1, 2'd1, 4'd8);
    tick();
    idle_in();
    tick();
    check_eq("rw_ready_low", in_ready, 0);
    rst_ni = 1'b0;
    #1;
    check_eq("rw_ready", in_ready, 1);
    check_eq("rw_we", rf_we, 0);
    check_eq("rw_waddr", rf_waddr, 0);
    check_eq("rw_wdata", rf_wdata, 0);
    check_eq("rw_timeout", mem_timeout, 0);
    check_eq("rw_spurious", spurious_rsp, 0);
    tick();
    rst_ni        = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 8'hFF;
    tick();
    mem_rsp_valid = 1'b0;
    check_eq("rw_late_we", rf_we, 0);
    check_eq("rw_late_spurious", spurious_rsp, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("rw_no_timeout", mem_timeout, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

- Parametrised register-file writeback stage for the 8-bit core, and the successor to the two-input ALU/memory write-value select.
- Selects one of N_SRC result sources and registers the write to the register file.
- When the source is memory, holds the instruction until the memory response arrives, or abandons it after TIMEOUT cycles.
- Sits between execute/memory and the register file; its registered write also serves as the forwarding source for execute.

## Interface
Parameters:
- DATA_W, 8, width of result and register data
- RA_W, 4, register address width
- N_SRC, 3, number of result sources (index 0 ALU, 1 memory, 2 immediate/link)
- MEM_SRC, 1, source index treated as the memory response
- TIMEOUT, 15, max cycles waited for a memory response (≥1)
- ZERO_REG, 1, when 1 writes to register 0 are suppressed

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction presented
- in_ready  out  1  unit can accept instruction this cycle
- in_reg_write  in  1  instruction writes a register
- in_src_sel  in  $clog2(N_SRC)  result source select
- in_rd  in  RA_W  destination register
- src_data  in  N_SRC×DATA_W  non-memory source values (entry MEM_SRC ignored)
- mem_rsp_valid  in  1  memory read data valid this cycle
- mem_rdata  in  DATA_W  memory read data
- rf_we  out  1  register write enable
- rf_waddr  out  RA_W  register write address
- rf_wdata  out  DATA_W  register write data
- mem_timeout  out  1  one-cycle pulse: pending load abandoned
- spurious_rsp  out  1  sticky: mem_rsp_valid seen with no load pending

## Operation
- Accept occurs when in_valid && in_ready.
- States are IDLE and WAIT_MEM. in_ready = (state == IDLE).
- IDLE, accept, in_reg_write=0:
  - No write; the instruction retires.
  - mem_rsp_valid is not consumed, even when in_src_sel == MEM_SRC.
- IDLE, accept, in_reg_write=1, in_src_sel ≠ MEM_SRC:
  - Next cycle: rf_we=1, rf_waddr=in_rd, rf_wdata=src_data[in_src_sel].
- IDLE, accept, in_reg_write=1, in_src_sel == MEM_SRC:
  - If mem_rsp_valid is high in the same cycle: write mem_rdata next cycle and stay in IDLE.
  - Otherwise: latch in_rd, clear the wait counter, and go to WAIT_MEM.
- WAIT_MEM:
  - The counter increments each cycle.
  - If mem_rsp_valid: write the latched rd with mem_rdata next cycle and go to IDLE.
  - Else if the counter reaches TIMEOUT: pulse mem_timeout next cycle, no write, go to IDLE.
  - A response in the same cycle as the counter reaching TIMEOUT wins: the write happens and there is no timeout.
- mem_rsp_valid in IDLE with no memory-source accept sets spurious_rsp; it stays set until reset. The data is discarded.
- in_src_sel ≥ N_SRC is treated as in_reg_write=0: no write.
- When ZERO_REG=1 and rd == 0, rf_we is forced low; the state machine still advances normally.
- After a rf_we cycle, rf_waddr/rf_wdata hold their values until the next write.

## Timing
- Reset (async assert, sync deassert by the surrounding design):
  - state=IDLE, counter=0
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - mem_timeout=0, spurious_rsp=0
  - in_ready=1 in the first cycle after reset.
- Latency:
  - Non-memory write: 1 cycle from accept.
  - Memory write: 1 cycle after the mem_rsp_valid cycle.
- Back-to-back non-memory instructions sustain one write per cycle.
- in_ready drops in the cycle after a waiting load is accepted. It returns to 1 in the cycle its rf_we/mem_timeout is asserted.
- rf_we, rf_waddr, rf_wdata and mem_timeout are registered outputs. in_ready is combinational from state only.
- Reset asserted mid-WAIT_MEM abandons the load: no write and no timeout pulse.

## Structure
- Package wb_pkg holds:
  - wb_state_t enum {WB_IDLE, WB_WAIT_MEM}
  - source index constants SRC_ALU=0, SRC_MEM=1, SRC_IMM=2
- Sub-module wb_src_mux: parametrised N_SRC×DATA_W combinational select. Out-of-range select returns 0.
- The wait counter is $clog2(TIMEOUT+1) bits wide.

## Test plan
- Reset, then accept ALU op with rd=3 and src_data[0]=8'h5A → next cycle rf_we=1, rf_waddr=3, rf_wdata=8'h5A; in_ready stays 1.
- Load to rd=4 with mem_rsp_valid in the same cycle and mem_rdata=8'hC3 → write 8'hC3 to r4 one cycle later; in_ready never drops.
- Load to rd=5 with response arriving 3 cycles after accept, mem_rdata=8'h11 → in_ready=0 for 3 cycles; rf_we for r5=8'h11 one cycle after the response.
- Load with no response, TIMEOUT=15 → mem_timeout pulses once, 16 cycles after accept; no rf_we; in_ready returns to 1.
- Write to rd=0 with ZERO_REG=1 → rf_we stays 0. A stray mem_rsp_valid in IDLE sets spurious_rsp, which stays high until rst_n=0.
- Assert rst_n=0 during WAIT_MEM, then deliver a response → all outputs 0, no write, and the later response sets spurious_rsp.
